phy_lane_sched: RTL and testbench
=================================

// Module: phy_lane_sched
// PURPOSE
//  Link controller and lane scheduler placed in front of the PHY TX serializer.
//  - Brings the serial link up by sending COM training symbols until the RX side
//    reports alignment.
//  - Then round-robin arbitrates four 8-bit lanes onto the single byte stream
//    feeding the parallel-to-serial stage.
//  - Sends IDL symbols when no lane has data.
// PARAMETERS
//  COM        8'hBC  training/alignment symbol
//  IDL        8'h7C  idle filler symbol in ACTIVE
//  TRAIN_LEN  4      min COM cycles in TRAIN before WAIT_RX (>=1)
//  TIMEOUT    16     WAIT_RX cycles without rx_active before retraining (>=1)
// PORTS
//  clk         in   1  single clock, all logic on posedge
//  reset       in   1  synchronous, active-low
//  In0..In3    in   8  lane data
//  valid0..3   in   1  lane data valid
//  ready0..3   out  1  lane accepted this cycle (transfer = valid_i & ready_i)
//  rx_active   in   1  RX aligner locked on COM stream
//  data_out    out  8  byte to serializer (registered)
//  valid_out   out  1  data_out carries lane payload (registered)
//  lane_out    out  2  source lane of data_out (registered)
//  link_up     out  1  high while in ACTIVE (registered)
// BEHAVIOUR
//  Reset (reset==0 at posedge):
//   - state=IDLE; data_out=0, valid_out=0, lane_out=0, link_up=0
//   - rr_ptr=0, cnt=0; ready0..3=0
//   - reset overrides everything, including mid-transfer; in-flight byte dropped
//  FSM, one transition per clk:
//   - IDLE -> TRAIN unconditionally
//   - TRAIN: data_out=COM, valid_out=0; cnt++.
//     cnt==TRAIN_LEN-1 -> WAIT_RX, cnt=0.
//   - WAIT_RX: data_out=COM, valid_out=0.
//     rx_active=1 -> ACTIVE.
//     else cnt==TIMEOUT-1 -> TRAIN, cnt=0; else cnt++.
//   - ACTIVE: link_up=1. rx_active=0 -> TRAIN, cnt=0, link_up=0 next cycle.
//  Arbitration (combinational, ACTIVE only):
//   - grant = first lane with valid_i set, searching rr_ptr, rr_ptr+1, ...
//     with mod-4 wrap
//   - ready_i = (state==ACTIVE) & rx_active & valid_i & (grant==i)
//   - at most one ready high per cycle; ready never high outside ACTIVE
//  Transfer (latency 1 clk):
//   - on transfer of lane g: next cycle data_out=In_g, valid_out=1,
//     lane_out=g, rr_ptr=(g+1) mod 4 (2-bit wrap 3->0)
//   - no transfer in ACTIVE: data_out=IDL, valid_out=0, lane_out and rr_ptr hold
//  Fairness: with all lanes continuously valid, grants are 0,1,2,3,0,...
//  and a lane waits at most 3 cycles.
//  Handshake: lane holds In_i/valid_i until it sees ready_i.
//  Dropping valid without ready is legal (no transfer).
//  rx_active drop: ready forced 0 in the same cycle; no byte is lost or
//  duplicated.
// TESTING
//  1. Reset low 2 clk, rx_active=0:
//     -> outputs 0; then IDLE, 4x COM (TRAIN), COM in WAIT_RX;
//        back to TRAIN after 16 cycles.
//  2. rx_active=1 during WAIT_RX -> link_up=1 next clk; idle lanes give
//     data_out=8'h7C, valid_out=0.
//  3. All valid, In0..3=8'h10,8'h21,8'h32,8'h43, held per handshake
//     -> data_out 10,21,32,43,10... with lane_out 0,1,2,3,0; one-clk latency.
//  4. Only valid2 and valid0, rr_ptr=3 -> grant 0 then 2 then 0;
//     ready1/ready3 never high.
//  5. rx_active drops while valid1=1
//     -> ready1=0 same cycle; TRAIN with COM next; link_up=0;
//        In1 sent once after relink.
//  6. reset low mid-stream in ACTIVE -> all outputs 0 next clk;
//     full retrain sequence from IDLE.

Source files
------------

// File: rtl/phy_lane_sched.sv
// phy_lane_sched: link bring-up FSM and round-robin 4-lane byte scheduler feeding the PHY TX serializer
module phy_lane_sched #(
  parameter logic [7:0] COM       = 8'hBC,
  parameter logic [7:0] IDL       = 8'h7C,
  parameter int         TRAIN_LEN = 4,
  parameter int         TIMEOUT   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] In0,
  input  logic [7:0] In1,
  input  logic [7:0] In2,
  input  logic [7:0] In3,
  input  logic       valid0,
  input  logic       valid1,
  input  logic       valid2,
  input  logic       valid3,
  output logic       ready0,
  output logic       ready1,
  output logic       ready2,
  output logic       ready3,
  input  logic       rx_active,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic [1:0] lane_out,
  output logic       link_up
);
  localparam int CW = $clog2(TIMEOUT > TRAIN_LEN ? TIMEOUT : TRAIN_LEN) + 1;
  typedef enum logic [1:0] {IDLE, TRAIN, WAIT_RX, ACTIVE} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    rr_ptr_q, rr_ptr_d;
  logic [7:0]    data_out_q, data_out_d;
  logic          valid_out_q, valid_out_d;
  logic [1:0]    lane_out_q, lane_out_d;
  logic          link_up_q, link_up_d;
  logic [7:0]    in_a [4];
  logic [3:0]    vld, rdy;
  logic [1:0]    grant;
  logic          found, xfer;
  assign in_a = '{In0, In1, In2, In3};
  assign vld = {valid3, valid2, valid1, valid0};
  assign xfer = (state_q == ACTIVE) & rx_active & found & reset;
  assign rdy = xfer ? 4'b0001 << grant : 4'b0000;
  assign {ready3, ready2, ready1, ready0} = rdy;
  assign data_out = data_out_q;
  assign valid_out = valid_out_q;
  assign lane_out = lane_out_q;
  assign link_up = link_up_q;
  // round-robin search from rr_ptr; iterating backwards lets the closest valid lane win
  always_comb begin
    grant = rr_ptr_q;
    found = 1'b0;
    for (int k = 3; k >= 0; k--)
      if (vld[rr_ptr_q + 2'(k)]) begin
        grant = rr_ptr_q + 2'(k);
        found = 1'b1;
      end
  end
  // link FSM next state; outputs are registered from the state being entered
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    unique case (state_q)
      IDLE: state_d = TRAIN;
      TRAIN: begin
        state_d = (cnt_q == CW'(TRAIN_LEN - 1)) ? WAIT_RX : TRAIN;
        cnt_d = (cnt_q == CW'(TRAIN_LEN - 1)) ? '0 : cnt_q + CW'(1);
      end
      WAIT_RX: begin
        state_d = rx_active ? ACTIVE : (cnt_q == CW'(TIMEOUT - 1)) ? TRAIN : WAIT_RX;
        cnt_d = (rx_active || cnt_q == CW'(TIMEOUT - 1)) ? '0 : cnt_q + CW'(1);
      end
      ACTIVE: begin
        state_d = rx_active ? ACTIVE : TRAIN;
        cnt_d = '0;
      end
    endcase
    data_out_d = (state_d == ACTIVE) ? (xfer ? in_a[grant] : IDL) : COM;
    valid_out_d = xfer;
    lane_out_d = xfer ? grant : lane_out_q;
    rr_ptr_d = xfer ? grant + 2'd1 : rr_ptr_q;
    link_up_d = state_d == ACTIVE;
  end
  // state and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rr_ptr_q <= '0;
      data_out_q <= '0;
      valid_out_q <= 1'b0;
      lane_out_q <= '0;
      link_up_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      data_out_q <= data_out_d;
      valid_out_q <= valid_out_d;
      lane_out_q <= lane_out_d;
      link_up_q <= link_up_d;
    end
  end
endmodule

// File: tb/tb_phy_lane_sched.sv
// tb_phy_lane_sched: random and directed stimulus against a phase/duration model with a queued scoreboard
module tb_phy_lane_sched;
  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] IDL = 8'h7C;
  localparam int TRAIN_LEN = 4;
  localparam int TIMEOUT = 16;
  typedef struct {logic [7:0] d; logic v; logic [1:0] l; logic u;} exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rx_active = 1'b0;
  logic [7:0] in0 = 0, in1 = 0, in2 = 0, in3 = 0;
  logic valid0 = 0, valid1 = 0, valid2 = 0, valid3 = 0;
  logic ready0, ready1, ready2, ready3;
  logic [7:0] data_out;
  logic valid_out, link_up;
  logic [1:0] lane_out;
  int checks = 0, passed = 0;
  exp_t exp_q[$];
  // lane-side view: pending byte per lane and offer controls
  bit pv[4];
  logic [7:0] pd[4];
  logic [7:0] fixed_val[4] = '{8'h10, 8'h21, 8'h32, 8'h43};
  bit [3:0] en = 4'h0;
  bit rand_mode = 0;
  // reference model: link phase name, cycles spent in phase, next lane to favour
  string m_ph = "IDLE";
  int m_t = 0, m_rr = 0, m_lane = 0;
  phy_lane_sched dut (
    .clk(clk), .reset(reset),
    .In0(in0), .In1(in1), .In2(in2), .In3(in3),
    .valid0(valid0), .valid1(valid1), .valid2(valid2), .valid3(valid3),
    .ready0(ready0), .ready1(ready1), .ready2(ready2), .ready3(ready3),
    .rx_active(rx_active), .data_out(data_out), .valid_out(valid_out),
    .lane_out(lane_out), .link_up(link_up)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
  endtask
  task automatic cycle(input bit rst_v, input bit rx_v);
    int g;
    exp_t e;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (rand_mode && pv[i] && $urandom_range(15) == 0) pv[i] = 0;
      if (!pv[i] && en[i] && (!rand_mode || $urandom_range(1) == 1)) begin
        pv[i] = 1;
        pd[i] = rand_mode ? 8'($urandom) : fixed_val[i];
      end
    end
    reset = rst_v;
    rx_active = rx_v;
    {valid3, valid2, valid1, valid0} = {pv[3], pv[2], pv[1], pv[0]};
    {in3, in2, in1, in0} = {pd[3], pd[2], pd[1], pd[0]};
    #1;
    g = -1;
    if (rst_v && m_ph == "ACTIVE" && rx_v)
      for (int k = 0; k < 4; k++)
        if (g < 0 && pv[(m_rr + k) % 4]) g = (m_rr + k) % 4;
    chk("ready", {ready3, ready2, ready1, ready0}, g < 0 ? 0 : (1 << g));
    if (!rst_v) begin
      m_ph = "IDLE"; m_t = 0; m_rr = 0; m_lane = 0;
      e = '{8'h00, 1'b0, 2'd0, 1'b0};
    end else begin
      if (m_ph == "IDLE") begin m_ph = "TRAIN"; m_t = 0; end
      else if (m_ph == "TRAIN") begin
        m_t++;
        if (m_t == TRAIN_LEN) begin m_ph = "WAIT_RX"; m_t = 0; end
      end else if (m_ph == "WAIT_RX") begin
        if (rx_v) m_ph = "ACTIVE";
        else begin
          m_t++;
          if (m_t == TIMEOUT) begin m_ph = "TRAIN"; m_t = 0; end
        end
      end else if (!rx_v) begin m_ph = "TRAIN"; m_t = 0; end
      if (g >= 0) begin m_lane = g; m_rr = (g + 1) % 4; pv[g] = 0; end
      e.u = m_ph == "ACTIVE";
      e.v = g >= 0;
      e.l = 2'(m_lane);
      e.d = m_ph != "ACTIVE" ? COM : g >= 0 ? pd[g] : IDL;
    end
    exp_q.push_back(e);
  endtask
  // monitor: compare every registered output against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("data_out", data_out, e.d);
        chk("valid_out", valid_out, e.v);
        chk("lane_out", lane_out, e.l);
        chk("link_up", link_up, e.u);
      end
    end
  end
  initial begin
    repeat (2) cycle(0, 0);
    repeat (30) cycle(1, 0);
    repeat (3) cycle(1, 1);
    en = 4'hF;
    repeat (12) cycle(1, 1);
    en = 4'h0;
    repeat (4) cycle(1, 1);
    en = 4'b0100;
    repeat (2) cycle(1, 1);
    en = 4'b0101;
    repeat (8) cycle(1, 1);
    en = 4'h0;
    repeat (4) cycle(1, 1);
    en = 4'b0010;
    repeat (6) cycle(1, 0);
    en = 4'h0;
    repeat (10) cycle(1, 1);
    en = 4'hF;
    repeat (3) cycle(1, 1);
    cycle(0, 1);
    repeat (30) cycle(1, 1);
    rand_mode = 1;
    begin
      bit rx = 1;
      for (int n = 0; n < 1500; n++) begin
        rx = rx ? ($urandom_range(39) != 0) : ($urandom_range(4) == 0);
        cycle($urandom_range(299) != 0, rx);
      end
    end
    @(posedge clk);
    #3;
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
